// File: rtl/mha_stream_attention_if.sv
// Handshake bundle for mha_stream_attention: query in, key/value tokens in, result out.
// The slave modport is the attention block's view; the master modport drives it.
interface mha_stream_attention_if #(
    parameter int HEADS  = 4,
    parameter int DIM    = 4,
    parameter int DATA_W = 16
);
    localparam int VEC_W = HEADS * DIM * DATA_W;

    logic             q_valid;
    logic             q_ready;
    logic [VEC_W-1:0] q_data;
    logic             kv_valid;
    logic             kv_ready;
    logic [VEC_W-1:0] k_data;
    logic [VEC_W-1:0] v_data;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_data;
    logic [HEADS-1:0] out_zero_sum;

    modport slave (
        input  q_valid, q_data, kv_valid, k_data, v_data, out_ready,
        output q_ready, kv_ready, out_valid, out_data, out_zero_sum
    );

    modport master (
        output q_valid, q_data, kv_valid, k_data, v_data, out_ready,
        input  q_ready, kv_ready, out_valid, out_data, out_zero_sum
    );
endinterface

// File: rtl/mha_stream_attention.sv
// Streaming multi-head attention: ReLU(q.k)-weighted average of SEQ_LEN value tokens per head.
// Optional score scaling (arithmetic right shift by SCALE_SHIFT) enabled by MHA_STREAM_SCALE_EN.
module mha_stream_attention #(
    parameter int HEADS   = 4,
    parameter int DIM     = 4,
    parameter int SEQ_LEN = 8,
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 64
`ifdef MHA_STREAM_SCALE_EN
    ,
    parameter int SCALE_SHIFT = 1
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mha_stream_attention_if.slave   bus,
    output logic                    busy
);
    localparam int VEC_W   = HEADS * DIM * DATA_W;
    localparam int SCORE_W = 2 * DATA_W + $clog2(DIM);
    localparam int PROD_W  = SCORE_W + DATA_W;
    localparam int CNT_W   = $clog2(SEQ_LEN + 1);

    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, OUT} state_t;

    state_t                   state, state_n;
    logic                     armed;
    logic [VEC_W-1:0]         q_reg;
    logic [CNT_W-1:0]         tok_cnt;
    logic signed [ACC_W-1:0]  acc   [HEADS][DIM];
    logic signed [ACC_W-1:0]  ssum  [HEADS];
    logic [VEC_W-1:0]         out_data_q;
    logic [HEADS-1:0]         out_zero_q;

    logic signed [SCORE_W-1:0] score_c  [HEADS];
    logic signed [SCORE_W-1:0] scaled_c [HEADS];
    logic signed [SCORE_W-1:0] weight_c [HEADS];
    logic signed [ACC_W-1:0]   acc_c    [HEADS][DIM];
    logic signed [ACC_W-1:0]   ssum_c   [HEADS];
    logic signed [ACC_W-1:0]   divisor_c[HEADS];
    logic signed [ACC_W-1:0]   quot_c   [HEADS][DIM];
    logic [VEC_W-1:0]          div_data_c;
    logic [HEADS-1:0]          div_zero_c;

    logic q_fire, kv_fire, out_fire, last_tok;

    function automatic logic signed [DATA_W-1:0] elem(input logic [VEC_W-1:0] vec,
                                                      input int h, input int d);
        return vec[(h*DIM+d)*DATA_W +: DATA_W];
    endfunction

    assign q_fire   = bus.q_valid  && bus.q_ready;
    assign kv_fire  = bus.kv_valid && bus.kv_ready;
    assign out_fire = bus.out_valid && bus.out_ready;
    assign last_tok = (tok_cnt == CNT_W'(SEQ_LEN - 1));

    assign bus.out_data     = out_data_q;
    assign bus.out_zero_sum = out_zero_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Holds q_ready low while reset is asserted, then releases it on the first clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) armed <= 1'b0;
        else          armed <= 1'b1;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n      = state;
        bus.q_ready  = 1'b0;
        bus.kv_ready = 1'b0;
        bus.out_valid = 1'b0;
        busy         = (state != IDLE);
        unique case (state)
            IDLE: begin
                bus.q_ready = armed;
                if (q_fire) state_n = ACCUM;
            end
            ACCUM: begin
                bus.kv_ready = 1'b1;
                if (kv_fire && last_tok) state_n = DIVIDE;
            end
            DIVIDE: state_n = OUT;
            OUT: begin
                bus.out_valid = 1'b1;
                if (out_fire) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        for (int h = 0; h < HEADS; h++) begin
            score_c[h] = '0;
            for (int d = 0; d < DIM; d++)
                score_c[h] = score_c[h] + SCORE_W'(elem(q_reg, h, d)) * SCORE_W'(elem(bus.k_data, h, d));
`ifdef MHA_STREAM_SCALE_EN
            scaled_c[h] = score_c[h] >>> SCALE_SHIFT;
`else
            scaled_c[h] = score_c[h];
`endif
            weight_c[h] = scaled_c[h][SCORE_W-1] ? '0 : scaled_c[h];
            ssum_c[h]   = ssum[h] + ACC_W'(weight_c[h]);
            for (int d = 0; d < DIM; d++)
                acc_c[h][d] = acc[h][d] + ACC_W'(PROD_W'(weight_c[h]) * PROD_W'(elem(bus.v_data, h, d)));
        end
    end

    // Zero-sum heads divide by 1 to keep the divider defined; their result is forced to 0 anyway.
    always_comb begin
        div_data_c = '0;
        for (int h = 0; h < HEADS; h++) begin
            div_zero_c[h] = (ssum[h] == '0);
            divisor_c[h]  = div_zero_c[h] ? ACC_W'(1) : ssum[h];
            for (int d = 0; d < DIM; d++) begin
                quot_c[h][d] = acc[h][d] / divisor_c[h];
                if (div_zero_c[h])
                    div_data_c[(h*DIM+d)*DATA_W +: DATA_W] = '0;
                else if (quot_c[h][d] > OUT_MAX)
                    div_data_c[(h*DIM+d)*DATA_W +: DATA_W] = OUT_MAX[DATA_W-1:0];
                else if (quot_c[h][d] < OUT_MIN)
                    div_data_c[(h*DIM+d)*DATA_W +: DATA_W] = OUT_MIN[DATA_W-1:0];
                else
                    div_data_c[(h*DIM+d)*DATA_W +: DATA_W] = quot_c[h][d][DATA_W-1:0];
            end
        end
    end

    // NOTE: accumulator arrays are reset explicitly so an aborted query leaves no residue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg      <= '0;
            tok_cnt    <= '0;
            out_data_q <= '0;
            out_zero_q <= '0;
            for (int h = 0; h < HEADS; h++) begin
                ssum[h] <= '0;
                for (int d = 0; d < DIM; d++) acc[h][d] <= '0;
            end
        end else begin
            if (q_fire) begin
                q_reg   <= bus.q_data;
                tok_cnt <= '0;
                for (int h = 0; h < HEADS; h++) begin
                    ssum[h] <= '0;
                    for (int d = 0; d < DIM; d++) acc[h][d] <= '0;
                end
            end
            if (kv_fire) begin
                acc     <= acc_c;
                ssum    <= ssum_c;
                tok_cnt <= tok_cnt + CNT_W'(1);
            end
            if (state == DIVIDE) begin
                out_data_q <= div_data_c;
                out_zero_q <= div_zero_c;
            end
        end
    end
endmodule

// File: tb/tb_mha_stream_attention.sv
// Directed bench for mha_stream_attention (SEQ_LEN=2): vector table plus backpressure and reset-abort sequences.
module tb_mha_stream_attention;
    localparam int HEADS   = 4;
    localparam int DIM     = 4;
    localparam int DATA_W  = 16;
    localparam int SEQ_LEN = 2;
    localparam int ACC_W   = 64;
    localparam int VW      = HEADS * DIM * DATA_W;
    localparam int HW      = DIM * DATA_W;
    localparam int BOUND   = 50;

    typedef struct {
        logic [VW-1:0]    q, k0, v0, k1, v1;
        logic [VW-1:0]    exp_data;
        logic [HEADS-1:0] exp_zero;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl [3];

    mha_stream_attention_if #(.HEADS(HEADS), .DIM(DIM), .DATA_W(DATA_W)) bus ();

    mha_stream_attention #(
        .HEADS(HEADS), .DIM(DIM), .SEQ_LEN(SEQ_LEN), .DATA_W(DATA_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [HW-1:0] hv(input int e0, input int e1, input int e2, input int e3);
        return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic send_query(input logic [VW-1:0] q);
        int n = 0;
        bus.q_data  = q;
        bus.q_valid = 1'b1;
        while (!bus.q_ready && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        check("q_ready wait", VW'(bus.q_ready), VW'(1));
        @(posedge clk); #1;
        bus.q_valid = 1'b0;
    endtask

    task automatic send_token(input logic [VW-1:0] k, input logic [VW-1:0] v, input int gap);
        int n = 0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            check("stall holds ACCUM", VW'({busy, bus.kv_ready, bus.out_valid}), VW'(3'b110));
        end
        bus.k_data   = k;
        bus.v_data   = v;
        bus.kv_valid = 1'b1;
        while (!bus.kv_ready && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        check("kv_ready wait", VW'(bus.kv_ready), VW'(1));
        @(posedge clk); #1;
        bus.kv_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input vec_t t);
        for (int h = 0; h < HEADS; h++)
            check($sformatf("%s data h%0d", tag, h), VW'(bus.out_data[h*HW +: HW]), VW'(t.exp_data[h*HW +: HW]));
        check($sformatf("%s zero_sum", tag), VW'(bus.out_zero_sum), VW'(t.exp_zero));
    endtask

    task automatic accept_and_check_idle(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check($sformatf("%s back to IDLE", tag),
              VW'({bus.out_valid, bus.q_ready, busy, bus.kv_ready}), VW'(4'b0100));
    endtask

    initial begin
        tbl[0].q  = {hv(1,0,0,0),  hv(127,0,0,0),      hv(1,1,0,0),     hv(1,0,0,0)};
        tbl[0].k0 = {hv(1,0,0,0),  hv(1,0,0,0),        hv(-1,-1,0,0),   hv(2,0,0,0)};
        tbl[0].v0 = {hv(-7,5,3,-1), hv(32767,0,0,0),   hv(5,6,7,8),     hv(10,20,30,40)};
        tbl[0].k1 = {hv(2,0,0,0),  hv(0,0,0,0),        hv(-1,-1,0,0),   hv(2,0,0,0)};
        tbl[0].v1 = {hv(0,0,0,0),  hv(-32768,-32768,-32768,-32768), hv(1,2,3,4), hv(30,40,50,60)};
`ifdef MHA_STREAM_SCALE_EN
        tbl[0].exp_data = {hv(0,0,0,0),  hv(32767,0,0,0), hv(0,0,0,0), hv(20,30,40,50)};
`else
        tbl[0].exp_data = {hv(-2,1,1,0), hv(32767,0,0,0), hv(0,0,0,0), hv(20,30,40,50)};
`endif
        tbl[0].exp_zero = 4'b0010;

        tbl[1].q  = {hv(-3,0,0,0),      hv(0,0,0,0), hv(2,0,0,0),  hv(1,2,3,4)};
        tbl[1].k0 = {hv(-5,0,0,0),      hv(5,5,5,5), hv(1,0,0,0),  hv(1,1,1,1)};
        tbl[1].v0 = {hv(-20,20,-1,1),   hv(1,1,1,1), hv(9,9,9,9),  hv(100,-100,50,0)};
        tbl[1].k1 = {hv(0,0,0,0),       hv(5,5,5,5), hv(3,0,0,0),  hv(-1,0,0,0)};
        tbl[1].v1 = {hv(0,0,0,0),       hv(1,1,1,1), hv(1,2,3,-5), hv(999,999,999,999)};
        tbl[1].exp_data = {hv(-20,20,-1,1), hv(0,0,0,0), hv(3,3,4,-1), hv(100,-100,50,0)};
        tbl[1].exp_zero = 4'b0100;

        tbl[2].q  = {hv(0,0,0,1),  hv(0,0,0,0), hv(-32768,0,0,0), hv(32767,32767,32767,32767)};
        tbl[2].k0 = {hv(0,0,0,3),  hv(1,2,3,4), hv(-32768,0,0,0), hv(32767,32767,32767,32767)};
        tbl[2].v0 = {hv(-32768,-32768,32767,32767), hv(7,7,7,7), hv(3,3,3,3), hv(1000,-5,7,0)};
        tbl[2].k1 = {hv(0,0,0,-3), hv(1,2,3,4), hv(1,0,0,0),      hv(32767,32767,32767,32767)};
        tbl[2].v1 = {hv(0,0,0,0),  hv(7,7,7,7), hv(100,100,100,100), hv(-1000,5,-7,0)};
        tbl[2].exp_data = {hv(-32768,-32768,32767,32767), hv(0,0,0,0), hv(3,3,3,3), hv(0,0,0,0)};
        tbl[2].exp_zero = 4'b0100;

        reset_n      = 1'b0;
        bus.q_valid  = 1'b0;
        bus.q_data   = '0;
        bus.kv_valid = 1'b0;
        bus.k_data   = '0;
        bus.v_data   = '0;
        bus.out_ready = 1'b0;

        #12;
        check("reset ctrl", VW'({bus.q_ready, bus.kv_ready, bus.out_valid, busy}), VW'(0));
        check("reset out_data", bus.out_data, VW'(0));
        check("reset zero_sum", VW'(bus.out_zero_sum), VW'(0));
        #10 reset_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset q_ready", VW'({bus.q_ready, busy}), VW'(2'b10));

        // Back-to-back tokens; out_valid must appear exactly two edges after the last token.
        for (int i = 0; i < 3; i++) begin
            send_query(tbl[i].q);
            send_token(tbl[i].k0, tbl[i].v0, 0);
            send_token(tbl[i].k1, tbl[i].v1, 0);
            check($sformatf("v%0d out_valid +1 edge", i), VW'(bus.out_valid), VW'(0));
            @(posedge clk); #1;
            check($sformatf("v%0d out_valid +2 edges", i), VW'(bus.out_valid), VW'(1));
            check_result($sformatf("v%0d", i), tbl[i]);
            accept_and_check_idle($sformatf("v%0d", i));
        end

        // Backpressure: one idle cycle before each token, result held for 5 cycles.
        send_query(tbl[1].q);
        send_token(tbl[1].k0, tbl[1].v0, 1);
        send_token(tbl[1].k1, tbl[1].v1, 1);
        begin
            int n = 0;
            while (!bus.out_valid && n < BOUND) begin
                @(posedge clk); #1; n++;
            end
            check("bp out_valid wait", VW'(bus.out_valid), VW'(1));
        end
        for (int c = 0; c < 5; c++) begin
            check_result($sformatf("bp hold%0d", c), tbl[1]);
            check($sformatf("bp hold%0d ready", c), VW'({bus.out_valid, bus.q_ready, bus.kv_ready}), VW'(3'b100));
            @(posedge clk); #1;
        end
        accept_and_check_idle("bp");
        @(posedge clk); #1;
        check("bp single acceptance", VW'({bus.out_valid, busy}), VW'(0));

        // Reset after one of two tokens aborts the query, then the table vector runs clean.
        send_query(tbl[0].q);
        send_token(tbl[0].k0, tbl[0].v0, 0);
        #2 reset_n = 1'b0;
        #1;
        check("abort ctrl", VW'({bus.q_ready, bus.kv_ready, bus.out_valid, busy}), VW'(0));
        check("abort out_data", bus.out_data, VW'(0));
        check("abort zero_sum", VW'(bus.out_zero_sum), VW'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        send_query(tbl[0].q);
        send_token(tbl[0].k0, tbl[0].v0, 0);
        send_token(tbl[0].k1, tbl[0].v1, 0);
        @(posedge clk); #1;
        check("after abort out_valid", VW'(bus.out_valid), VW'(1));
        check_result("after abort", tbl[0]);
        accept_and_check_idle("after abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
